// File: rtl/csa_resp_analyzer_if.sv
// Response-side bundle between the carry-select adder under test and its response analyzer.
// The master side drives test mode and responses; the slave side returns the committed repair.
interface csa_resp_analyzer_if #(
  parameter int unsigned NBLK = 4,
  parameter int unsigned RW   = 6
);
  logic                 test;
  logic [NBLK*RW-1:0]   actual_output;
  logic [RW-1:0]        desired_output;
  logic [2:0]           is;
  logic [NBLK-1:0]      ss;
  logic [NBLK-1:0]      comp;
  logic [3:0]           fault_cnt;
  logic                 multi_fault;
  logic                 done;

  modport master (
    output test, actual_output, desired_output,
    input  is, ss, comp, fault_cnt, multi_fault, done
  );

  modport slave (
    input  test, actual_output, desired_output,
    output is, ss, comp, fault_cnt, multi_fault, done
  );
endinterface

// File: rtl/csa_resp_analyzer.sv
// Self-test response analyzer: compares each adder block against the reference over a fixed
// window, then commits and holds an isolation/spare repair decision.
module csa_resp_analyzer #(
  parameter int unsigned NUM_VEC = 8,
  parameter int unsigned NBLK    = 4,
  parameter int unsigned RW      = 6
) (
  input logic               clk,
  input logic               init_n,
  csa_resp_analyzer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDecide, StDone} state_e;

  state_e          state_q, state_d;
  logic [NBLK-1:0] fl_q, fl_d;
  logic [3:0]      mc_q [NBLK];
  logic [3:0]      mc_d [NBLK];
  logic [7:0]      vc_q, vc_d;

  logic [2:0]      is_q, is_d;
  logic [NBLK-1:0] ss_q, ss_d;
  logic [NBLK-1:0] comp_q, comp_d;
  logic [3:0]      fault_cnt_q, fault_cnt_d;
  logic            multi_fault_q, multi_fault_d;
  logic            done_q, done_d;

  logic [NBLK-1:0] mismatch;
  logic [2:0]      nfail;
  logic [1:0]      fail_idx;
  logic [3:0]      mc_max;

  // Any differing bit marks the block as failing for this sample.
  always_comb begin
    mismatch = '0;
    for (int k = 0; k < int'(NBLK); k++) begin
      mismatch[k] = (bus.actual_output[RW*k +: RW] != bus.desired_output);
    end
  end

  always_comb begin
    nfail    = '0;
    fail_idx = '0;
    mc_max   = '0;
    for (int k = 0; k < int'(NBLK); k++) begin
      if (fl_q[k]) begin
        nfail    = nfail + 3'd1;
        fail_idx = 2'(k);
      end
      if (mc_q[k] > mc_max) mc_max = mc_q[k];
    end
  end

  always_comb begin
    state_d       = state_q;
    fl_d          = fl_q;
    mc_d          = mc_q;
    vc_d          = vc_q;
    is_d          = is_q;
    ss_d          = ss_q;
    comp_d        = comp_q;
    fault_cnt_d   = fault_cnt_q;
    multi_fault_d = multi_fault_q;
    done_d        = done_q;

    unique case (state_q)
      StIdle: begin
        fl_d = '0;
        for (int k = 0; k < int'(NBLK); k++) mc_d[k] = '0;
        vc_d = '0;
        if (bus.test) state_d = StRun;
      end
      StRun: begin
        if (!bus.test) begin
          state_d = StIdle;
        end else begin
          for (int k = 0; k < int'(NBLK); k++) begin
            if (mismatch[k]) begin
              fl_d[k] = 1'b1;
              if (mc_q[k] != 4'd15) mc_d[k] = mc_q[k] + 4'd1;
            end
          end
          vc_d = vc_q + 8'd1;
          if (vc_q == 8'(NUM_VEC - 1)) state_d = StDecide;
        end
      end
      StDecide: begin
        comp_d      = fl_q;
        fault_cnt_d = mc_max;
        if (nfail == 3'd0) begin
          is_d          = 3'b000;
          ss_d          = '0;
          multi_fault_d = 1'b0;
        end else if (nfail == 3'd1) begin
          is_d          = {1'b1, fail_idx};
          ss_d          = NBLK'(1) << fail_idx;
          multi_fault_d = 1'b0;
        end else begin
          is_d          = 3'b011;
          ss_d          = '0;
          multi_fault_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        // Committed repair stays on the muxes after test mode ends.
        if (!bus.test) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q       <= StIdle;
      fl_q          <= '0;
      for (int k = 0; k < int'(NBLK); k++) mc_q[k] <= '0;
      vc_q          <= '0;
      is_q          <= '0;
      ss_q          <= '0;
      comp_q        <= '0;
      fault_cnt_q   <= '0;
      multi_fault_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fl_q          <= fl_d;
      for (int k = 0; k < int'(NBLK); k++) mc_q[k] <= mc_d[k];
      vc_q          <= vc_d;
      is_q          <= is_d;
      ss_q          <= ss_d;
      comp_q        <= comp_d;
      fault_cnt_q   <= fault_cnt_d;
      multi_fault_q <= multi_fault_d;
      done_q        <= done_d;
    end
  end

  assign bus.is          = is_q;
  assign bus.ss          = ss_q;
  assign bus.comp        = comp_q;
  assign bus.fault_cnt   = fault_cnt_q;
  assign bus.multi_fault = multi_fault_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_csa_resp_analyzer.sv
// Directed bench for csa_resp_analyzer: an 8-vector instance for the decision scenarios and
// a 20-vector instance for counter saturation and asynchronous reset.
module tb_csa_resp_analyzer;

  logic clk;
  logic init_n;
  int   checks;
  int   errors;

  csa_resp_analyzer_if #(.NBLK(4), .RW(6)) bi ();
  csa_resp_analyzer_if #(.NBLK(4), .RW(6)) bs ();

  csa_resp_analyzer #(.NUM_VEC(8), .NBLK(4), .RW(6)) dut (
    .clk    (clk),
    .init_n (init_n),
    .bus    (bi)
  );

  csa_resp_analyzer #(.NUM_VEC(20), .NBLK(4), .RW(6)) dut_sat (
    .clk    (clk),
    .init_n (init_n),
    .bus    (bs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bit0 is clear on 5 of these 8 vectors
  logic [5:0] dvec [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 clean, 1 blk2 bit0 stuck-at-1, 2 blk0+blk3 always wrong,
  // 3 blk1 wrong on the final sample only, 4 blk0 always wrong
  task automatic run_window(input int mode, input int abort_at);
    logic [5:0] d;
    logic [5:0] b [4];
    bi.test = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      d = dvec[i];
      for (int k = 0; k < 4; k++) b[k] = d;
      case (mode)
        1: b[2] = d | 6'h01;
        2: begin b[0] = d ^ 6'h3f; b[3] = d ^ 6'h15; end
        3: if (i == 7) b[1] = d ^ 6'h20;
        4: b[0] = d ^ 6'h01;
        default: ;
      endcase
      bi.desired_output = d;
      bi.actual_output  = {b[3], b[2], b[1], b[0]};
      if (i == abort_at) begin
        bi.test = 1'b0;
        step();
        return;
      end
      step();
    end
  endtask

  task automatic end_window();
    bi.test = 1'b0;
    step();
  endtask

  task automatic test_reset();
    init_n = 1'b0;
    bi.test = 1'b0; bi.actual_output = '0; bi.desired_output = '0;
    bs.test = 1'b0; bs.actual_output = '0; bs.desired_output = '0;
    step(); step();
    checks++;
    if ({bi.is, bi.ss, bi.comp, bi.fault_cnt, bi.multi_fault, bi.done} !== 17'h0) begin
      errors++;
      $display("FAIL reset_outputs got is=%b ss=%b comp=%b fc=%0d mf=%b done=%b required all 0",
               bi.is, bi.ss, bi.comp, bi.fault_cnt, bi.multi_fault, bi.done);
    end
    init_n = 1'b1;
    step();
    checks++;
    if (bi.done !== 1'b0) begin
      errors++; $display("FAIL reset_done_after_release got %b required 0", bi.done);
    end
  endtask

  task automatic test_clean();
    run_window(0, -1);
    checks++;
    if (bi.done !== 1'b0) begin
      errors++; $display("FAIL clean_done_early got %b required 0", bi.done);
    end
    step();
    checks++;
    if (bi.done !== 1'b1) begin
      errors++; $display("FAIL clean_done_latency got %b required 1", bi.done);
    end
    checks++;
    if ({bi.is, bi.ss, bi.comp, bi.fault_cnt, bi.multi_fault} !== 16'h0) begin
      errors++;
      $display("FAIL clean_decision got is=%b ss=%b comp=%b fc=%0d mf=%b required 000/0000/0000/0/0",
               bi.is, bi.ss, bi.comp, bi.fault_cnt, bi.multi_fault);
    end
    end_window();
  endtask

  task automatic test_single_fault();
    run_window(1, -1);
    step();
    checks++;
    if (bi.done !== 1'b1) begin
      errors++; $display("FAIL single_done got %b required 1", bi.done);
    end
    checks++;
    if (bi.is !== 3'b110 || bi.ss !== 4'b0100 || bi.comp !== 4'b0100) begin
      errors++;
      $display("FAIL single_repair got is=%b ss=%b comp=%b required 110/0100/0100",
               bi.is, bi.ss, bi.comp);
    end
    checks++;
    if (bi.fault_cnt !== 4'd5 || bi.multi_fault !== 1'b0) begin
      errors++;
      $display("FAIL single_count got fc=%0d mf=%b required 5/0", bi.fault_cnt, bi.multi_fault);
    end
    end_window();
    checks++;
    if (bi.done !== 1'b0 || bi.is !== 3'b110 || bi.fault_cnt !== 4'd5) begin
      errors++;
      $display("FAIL single_hold got done=%b is=%b fc=%0d required 0/110/5",
               bi.done, bi.is, bi.fault_cnt);
    end
  endtask

  task automatic test_multi_fault();
    run_window(2, -1);
    step();
    checks++;
    if (bi.is !== 3'b011 || bi.ss !== 4'b0000 || bi.comp !== 4'b1001) begin
      errors++;
      $display("FAIL multi_repair got is=%b ss=%b comp=%b required 011/0000/1001",
               bi.is, bi.ss, bi.comp);
    end
    checks++;
    if (bi.fault_cnt !== 4'd8 || bi.multi_fault !== 1'b1 || bi.done !== 1'b1) begin
      errors++;
      $display("FAIL multi_count got fc=%0d mf=%b done=%b required 8/1/1",
               bi.fault_cnt, bi.multi_fault, bi.done);
    end
    end_window();
  endtask

  task automatic test_final_sample();
    run_window(3, -1);
    step();
    checks++;
    if (bi.is !== 3'b101 || bi.ss !== 4'b0010 || bi.comp !== 4'b0010) begin
      errors++;
      $display("FAIL final_repair got is=%b ss=%b comp=%b required 101/0010/0010",
               bi.is, bi.ss, bi.comp);
    end
    checks++;
    if (bi.fault_cnt !== 4'd1 || bi.multi_fault !== 1'b0) begin
      errors++;
      $display("FAIL final_count got fc=%0d mf=%b required 1/0", bi.fault_cnt, bi.multi_fault);
    end
    end_window();
  endtask

  task automatic test_abort();
    run_window(1, -1);
    step();
    end_window();
    run_window(4, 4);
    step(); step(); step(); step();
    checks++;
    if (bi.done !== 1'b0) begin
      errors++; $display("FAIL abort_done got %b required 0", bi.done);
    end
    checks++;
    if (bi.is !== 3'b110 || bi.ss !== 4'b0100 || bi.comp !== 4'b0100 || bi.fault_cnt !== 4'd5) begin
      errors++;
      $display("FAIL abort_hold got is=%b ss=%b comp=%b fc=%0d required 110/0100/0100/5",
               bi.is, bi.ss, bi.comp, bi.fault_cnt);
    end
    run_window(0, -1);
    step();
    checks++;
    if (bi.done !== 1'b1 || bi.is !== 3'b000 || bi.ss !== 4'b0000 || bi.fault_cnt !== 4'd0) begin
      errors++;
      $display("FAIL abort_rerun got done=%b is=%b ss=%b fc=%0d required 1/000/0000/0",
               bi.done, bi.is, bi.ss, bi.fault_cnt);
    end
    end_window();
  endtask

  task automatic test_saturation_and_reset();
    logic [5:0] d;
    bs.test = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      d = 6'(i * 3 + 1);
      bs.desired_output = d;
      bs.actual_output  = {~d, d, d, d};
      step();
    end
    checks++;
    if (bs.done !== 1'b0) begin
      errors++; $display("FAIL sat_done_early got %b required 0", bs.done);
    end
    step();
    checks++;
    if (bs.done !== 1'b1 || bs.fault_cnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_count got done=%b fc=%0d required 1/15", bs.done, bs.fault_cnt);
    end
    checks++;
    if (bs.is !== 3'b111 || bs.ss !== 4'b1000 || bs.comp !== 4'b1000 || bs.multi_fault !== 1'b0) begin
      errors++;
      $display("FAIL sat_repair got is=%b ss=%b comp=%b mf=%b required 111/1000/1000/0",
               bs.is, bs.ss, bs.comp, bs.multi_fault);
    end
    #2;
    init_n = 1'b0;
    #1;
    checks++;
    if ({bs.is, bs.ss, bs.comp, bs.fault_cnt, bs.multi_fault, bs.done} !== 17'h0) begin
      errors++;
      $display("FAIL sat_async_reset got is=%b ss=%b comp=%b fc=%0d mf=%b done=%b required all 0",
               bs.is, bs.ss, bs.comp, bs.fault_cnt, bs.multi_fault, bs.done);
    end
    bs.test = 1'b0;
    step();
    init_n = 1'b1;
    step();
    // A fresh clean window with full latency shows the FSM restarted from idle.
    bs.actual_output  = {4{6'h2a}};
    bs.desired_output = 6'h2a;
    bs.test = 1'b1;
    step();
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (bs.done !== 1'b0) begin
      errors++; $display("FAIL sat_rerun_early got %b required 0", bs.done);
    end
    step();
    checks++;
    if (bs.done !== 1'b1 || bs.is !== 3'b000 || bs.fault_cnt !== 4'd0) begin
      errors++;
      $display("FAIL sat_rerun got done=%b is=%b fc=%0d required 1/000/0",
               bs.done, bs.is, bs.fault_cnt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    dvec = '{6'h02, 6'h04, 6'h11, 6'h08, 6'h23, 6'h10, 6'h3e, 6'h15};
    test_reset();
    test_clean();
    test_single_fault();
    test_multi_fault();
    test_final_sample();
    test_abort();
    test_saturation_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
